// File: rtl/run_launcher.sv
// Host-side initiator: launches NUM_RUNS req/ack runs per go pulse and reports per-run cycle counts.
// Optional abort-on-timeout in WAIT is enabled by defining RUN_LAUNCH_TIMEOUT_EN.
module run_launcher #(
  parameter int unsigned NUM_RUNS   = 3,
  parameter int unsigned REQ_CYCLES = 2,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 4000,
  localparam int unsigned IDX_W     = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             ack,
  output logic             req,
  output logic [IDX_W-1:0] run_idx,
  output logic [CNT_W-1:0] cycles,
  output logic             cycles_vld,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StGap, StDone, StErr} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             req_q, req_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cycles_q <= '0;
      idx_q    <= '0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // One shared counter times REQ hold, WAIT latency and GAP length; it is cleared on every entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    idx_d    = idx_q;
    req_d    = req_q;
    vld_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (go) begin
          state_d = StReq;
          cnt_d   = '0;
          req_d   = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        if (cnt_q == CNT_W'(REQ_CYCLES - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        if (ack) begin
          cycles_d = cnt_q;
          vld_d    = 1'b1;
          cnt_d    = '0;
          if (idx_q == IDX_W'(NUM_RUNS - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (GAP_CYCLES == 0) begin
              state_d = StReq;
              req_d   = 1'b1;
            end else begin
              state_d = StGap;
            end
          end
        end
`ifdef RUN_LAUNCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = StErr;
          cycles_d = CNT_W'(TIMEOUT);
          vld_d    = 1'b1;
          busy_d   = 1'b0;
          err_d    = 1'b1;
        end
`endif
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = StReq;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifndef RUN_LAUNCH_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign req         = req_q;
  assign run_idx     = idx_q;
  assign cycles      = cycles_q;
  assign cycles_vld  = vld_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_run_launcher.sv
// Bench for run_launcher: table-driven batches on a default instance, plus hand sequences
// for reset-abort, zero-gap relaunch and (with RUN_LAUNCH_TIMEOUT_EN) timeout on a second instance.
module tb_run_launcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        go_a = 1'b0, ack_a = 1'b0;
  logic        req_a, vld_a, busy_a, done_a, err_a;
  logic [1:0]  idx_a;
  logic [15:0] cyc_a;

  logic        go_b = 1'b0, ack_b = 1'b0;
  logic        req_b, vld_b, busy_b, done_b, err_b;
  logic [1:0]  idx_b;
  logic [15:0] cyc_b;

  run_launcher dut_a (
    .clock(clk), .reset(rst), .go(go_a), .ack(ack_a), .req(req_a), .run_idx(idx_a),
    .cycles(cyc_a), .cycles_vld(vld_a), .busy(busy_a), .done(done_a), .timeout_err(err_a)
  );

  run_launcher #(.GAP_CYCLES(0), .TIMEOUT(20)) dut_b (
    .clock(clk), .reset(rst), .go(go_b), .ack(ack_b), .req(req_b), .run_idx(idx_b),
    .cycles(cyc_b), .cycles_vld(vld_b), .busy(busy_b), .done(done_b), .timeout_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dly;      // WAIT cycles before ack rises
    bit hold;     // ack held high across the whole batch
    bit spam;     // go held high while busy
    int exp_cyc;  // expected cycles per run
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_batch(input vec_t v);
    int n;
    ack_a = v.hold;
    go_a  = 1'b1;
    tick();
    go_a = v.spam;
    chk("go_busy", busy_a, 1);
    chk("go_req", req_a, 1);
    chk("go_idx", idx_a, 0);
    chk("go_done", done_a, 0);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!req_a && n < 50) begin n++; tick(); end
      if (r > 0) chk("gap_len", n, 1);
      n = 0;
      while (req_a && n < 50) begin n++; tick(); end
      chk("req_len", n, 2);
      repeat (v.dly) tick();
      ack_a = 1'b1;
      tick();
      chk("cyc_vld", vld_a, 1);
      chk("cycles", cyc_a, v.exp_cyc);
      chk("run_idx", idx_a, (r < 2) ? r + 1 : 2);
      ack_a = v.hold;
      if (r == 2) go_a = 1'b0;
    end
    chk("done", done_a, 1);
    chk("busy_end", busy_a, 0);
    tick();
    chk("vld_pulse", vld_a, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_a) n++;
      tick();
    end
    chk("no_extra_req", n, 0);
    chk("done_held", done_a, 1);
    ack_a = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   n;
    vecs[0] = '{dly: 10, hold: 1'b0, spam: 1'b0, exp_cyc: 10};
    vecs[1] = '{dly: 0,  hold: 1'b1, spam: 1'b0, exp_cyc: 0};
    vecs[2] = '{dly: 4,  hold: 1'b0, spam: 1'b1, exp_cyc: 4};
    vecs[3] = '{dly: 1,  hold: 1'b0, spam: 1'b0, exp_cyc: 1};

    tick();
    tick();
    chk("rst_req", req_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_cyc", cyc_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_req_b", req_b, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_batch(vecs[i]);

    // Reset during WAIT of run 1 aborts immediately.
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    n = 0;
    while (req_a && n < 50) begin n++; tick(); end
    repeat (2) tick();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    n = 0;
    while (!req_a && n < 50) begin n++; tick(); end
    n = 0;
    while (req_a && n < 50) begin n++; tick(); end
    tick();
    chk("mid_idx", idx_a, 1);
    chk("mid_busy", busy_a, 1);
    rst = 1'b1;
    tick();
    chk("abort_req", req_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_idx", idx_a, 0);
    chk("abort_cyc", cyc_a, 0);
    rst = 1'b0;
    tick();
    run_batch('{dly: 3, hold: 1'b0, spam: 1'b0, exp_cyc: 3});

    // Zero gap: req relaunches the cycle after ack is sampled.
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    n = 0;
    while (req_b && n < 50) begin n++; tick(); end
    chk("b_req_len", n, 2);
    tick();
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    chk("b_vld", vld_b, 1);
    chk("b_cycles", cyc_b, 1);
    chk("b_req_again", req_b, 1);
    chk("b_idx", idx_b, 1);
    n = 0;
    while (req_b && n < 50) begin n++; tick(); end
    chk("b_req_len2", n, 2);
`ifdef RUN_LAUNCH_TIMEOUT_EN
    repeat (19) tick();
    chk("to_pre_err", err_b, 0);
    chk("to_pre_busy", busy_b, 1);
    tick();
    chk("to_err", err_b, 1);
    chk("to_cycles", cyc_b, 20);
    chk("to_vld", vld_b, 1);
    chk("to_busy", busy_b, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_b) n++;
      tick();
    end
    chk("to_no_req", n, 0);
    chk("to_err_held", err_b, 1);
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    chk("to_clear", err_b, 0);
    chk("to_restart", req_b, 1);
    chk("to_idx", idx_b, 0);
`else
    repeat (30) tick();
    chk("nto_err", err_b, 0);
    chk("nto_busy", busy_b, 1);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    chk("nto_cycles", cyc_b, 30);
    chk("nto_vld", vld_b, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
